// File: rtl/cpu_pkg.sv
// Shared cpu types and constants: word/address/instruction widths, reset PC,
// and the instruction-to-word split used by the program loader.
package cpu_pkg;

  localparam int WORD_W          = 10;
  localparam int WORDS_PER_INSTR = 3;

  typedef logic [WORD_W-1:0]                 word_t;
  typedef logic [13:0]                       addr_t;
  typedef logic [WORDS_PER_INSTR*WORD_W-1:0] instr_t;

  localparam addr_t RESET_PC = 14'h2000;

  // One buffered host transfer: the instruction plus its end-of-program marker.
  typedef struct packed {
    logic   last;
    instr_t data;
  } fifo_entry_t;

  // Word idx 0 is the most significant slice, matching the cpu fetch order.
  function automatic word_t instr_word(input instr_t instr, input logic [1:0] idx);
    return instr[(WORDS_PER_INSTR - 1 - int'(idx)) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered storage, push/pop/flush and full/empty flags.
// Read data is the head entry, valid whenever empty is low.
module instr_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/instr_loader.sv
// Host-side program writer: buffers 30-bit instructions, writes them as three
// 10-bit words from BASE_ADDR upward, and holds the cpu in reset until done.
module instr_loader
  import cpu_pkg::*;
#(
  parameter addr_t BASE_ADDR  = RESET_PC,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [29:0]  in_data,
  input  logic         in_last,
  input  logic         start,
  output logic [13:0]  mem_addr,
  output logic [9:0]   mem_wdata,
  output logic         mem_we,
  output logic         cpu_hold,
  output logic         done,
  output logic         err,
  output logic [11:0]  instr_count
);

  typedef enum logic [2:0] {
    WAIT,
    W0,
    W1,
    W2,
    DONE,
    ERR
  } loader_state_t;

  localparam int    ENTRY_W   = $bits(fifo_entry_t);
  localparam addr_t LAST_ADDR = '1;

  loader_state_t state;
  loader_state_t next_state;
  addr_t         ptr;
  fifo_entry_t   hold;
  logic [11:0]   count;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               restart;
  logic               count_inc;
  logic               writing;
  logic [ENTRY_W-1:0] fifo_rdata;
  fifo_entry_t        fifo_head;
  logic [1:0]         word_idx;

  assign in_ready  = !fifo_full && (state != DONE) && (state != ERR);
  assign fifo_push = in_valid && in_ready;
  assign fifo_head = fifo_rdata;

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (restart),
    .wdata ({in_last, in_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT;
    else     state <= next_state;
  end

  // W2 pops the next instruction directly so back-to-back loads have no idle cycle.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    restart    = 1'b0;
    count_inc  = 1'b0;
    case (state)
      WAIT: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = W0;
        end
      end
      W0: next_state = W1;
      W1: next_state = W2;
      W2: begin
        count_inc = 1'b1;
        if (hold.last) begin
          next_state = DONE;
        end else if (ptr == LAST_ADDR) begin
          next_state = ERR;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = W0;
        end else begin
          next_state = WAIT;
        end
      end
      DONE, ERR: begin
        if (start) begin
          restart    = 1'b1;
          next_state = WAIT;
        end
      end
      default: next_state = WAIT;
    endcase
  end

  assign writing = (state == W0) || (state == W1) || (state == W2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= BASE_ADDR;
      hold  <= '0;
      count <= '0;
    end else begin
      if (restart)      ptr <= BASE_ADDR;
      else if (writing) ptr <= ptr + 14'd1;

      if (fifo_pop) hold <= fifo_head;

      if (restart)                         count <= '0;
      else if (count_inc && count != '1)   count <= count + 12'd1;
    end
  end

  // Memory-side outputs decode only registered state, never the host inputs.
  always_comb begin
    word_idx = 2'd0;
    case (state)
      W1:      word_idx = 2'd1;
      W2:      word_idx = 2'd2;
      default: word_idx = 2'd0;
    endcase
  end

  assign mem_we      = writing;
  assign mem_addr    = ptr;
  assign mem_wdata   = writing ? instr_word(hold.data, word_idx) : '0;
  assign cpu_hold    = (state != DONE);
  assign done        = (state == DONE);
  assign err         = (state == ERR);
  assign instr_count = count;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: one task per scenario, write log captured
// on the falling edge and compared against the instructions the bench sent.
module tb_instr_loader;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, start;
  logic [29:0] in_data;
  logic [13:0] mem_addr;
  logic [9:0]  mem_wdata;
  logic        mem_we, cpu_hold, done, err;
  logic [11:0] instr_count;

  logic        o_in_valid, o_in_ready, o_in_last, o_start;
  logic [29:0] o_in_data;
  logic [13:0] o_mem_addr;
  logic [9:0]  o_mem_wdata;
  logic        o_mem_we, o_cpu_hold, o_done, o_err;
  logic [11:0] o_instr_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  bit saw_stall;

  addr_t  wr_addr[$];
  word_t  wr_data[$];
  int     wr_cyc[$];
  addr_t  o_wr_addr[$];
  word_t  o_wr_data[$];
  instr_t sent_q[$];

  always #5 clk = ~clk;

  instr_loader #(.BASE_ADDR(14'h2000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .start(start), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .cpu_hold(cpu_hold), .done(done), .err(err), .instr_count(instr_count)
  );

  instr_loader #(.BASE_ADDR(14'h3FFA), .FIFO_DEPTH(4)) dut_ovf (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data),
    .in_last(o_in_last), .start(o_start), .mem_addr(o_mem_addr), .mem_wdata(o_mem_wdata),
    .mem_we(o_mem_we), .cpu_hold(o_cpu_hold), .done(o_done), .err(o_err),
    .instr_count(o_instr_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (o_mem_we === 1'b1) begin
      o_wr_addr.push_back(o_mem_addr);
      o_wr_data.push_back(o_mem_wdata);
    end
  end

  function automatic word_t split(input instr_t v, input int j);
    case (j)
      0:       return v[29:20];
      1:       return v[19:10];
      default: return v[9:0];
    endcase
  endfunction

  function automatic instr_t pat(input int i);
    logic [9:0] b;
    b = 10'(i);
    return {10'h100 ^ b, 10'h2A0 ^ b, 10'h015 ^ b};
  endfunction

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); sent_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input instr_t d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int t = 0; t < 200; t++) begin
      if (in_ready === 1'b1) begin
        sent_q.push_back(d);
        last_acc = cyc;
        @(negedge clk);
        return;
      end
      saw_stall = 1'b1;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("[TB] FAIL send_timeout: in_ready=%b, required 1", in_ready);
  endtask

  task automatic o_send(input instr_t d);
    o_in_valid = 1'b1; o_in_data = d; o_in_last = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (o_in_ready === 1'b1) begin
        sent_q.push_back(d);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("[TB] FAIL ovf_send_timeout: in_ready=%b, required 1", o_in_ready);
  endtask

  task automatic wait_done(input int budget);
    for (int t = 0; t < budget; t++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("[TB] FAIL done_timeout: done=%b, required 1", done);
  endtask

  task automatic wait_write(input addr_t a);
    for (int t = 0; t < 100; t++) begin
      if (mem_we === 1'b1 && mem_addr === a) return;
      @(negedge clk);
    end
    n_checks++; n_fail++;
    $display("[TB] FAIL write_timeout: no write seen at %h", a);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; start = 1'b0;
    o_in_valid = 1'b0; o_in_data = '0; o_in_last = 1'b0; o_start = 1'b0;
    tick(2);
    if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_we: got %b want 0", mem_we); end
    n_checks++;
    if (mem_addr !== 14'h2000) begin n_fail++; $display("[TB] FAIL rst_addr: got %h want 2000", mem_addr); end
    n_checks++;
    if (mem_wdata !== 10'h000) begin n_fail++; $display("[TB] FAIL rst_wdata: got %h want 000", mem_wdata); end
    n_checks++;
    if ({in_ready, cpu_hold, done, err} !== 4'b1100) begin
      n_fail++; $display("[TB] FAIL rst_flags: got ready/hold/done/err=%b want 1100", {in_ready, cpu_hold, done, err});
    end
    n_checks++;
    if (instr_count !== 12'd0) begin n_fail++; $display("[TB] FAIL rst_count: got %0d want 0", instr_count); end
    n_checks++;
    rst = 1'b0;
    tick(1);
    if (mem_we !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++; $display("[TB] FAIL idle_after_rst: we=%b hold=%b want 0/1", mem_we, cpu_hold);
    end
    n_checks++;
  endtask

  task automatic test_single();
    instr_t v;
    word_t  exp_w [3];
    v = {10'h3FF, 10'h155, 10'h2AA};
    exp_w = '{10'h3FF, 10'h155, 10'h2AA};
    clear_log();
    send(v, 1'b1);
    in_valid = 1'b0;
    wait_done(50);
    if (wr_addr.size() !== 3) begin
      n_fail++; $display("[TB] FAIL single_count: got %0d writes want 3", wr_addr.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr_addr[k] !== addr_t'(14'h2000 + k) || wr_data[k] !== exp_w[k]) begin
          n_fail++; $display("[TB] FAIL single_word%0d: got %h<=%h want %h<=%h", k, wr_addr[k], wr_data[k], 14'h2000 + k, exp_w[k]);
        end
        n_checks++;
        if (wr_cyc[k] !== last_acc + 2 + k) begin
          n_fail++; $display("[TB] FAIL single_timing%0d: got cycle %0d want %0d", k, wr_cyc[k], last_acc + 2 + k);
        end
        n_checks++;
      end
    end
    n_checks++;
    if ({done, cpu_hold, in_ready} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL single_done: got done/hold/ready=%b want 100", {done, cpu_hold, in_ready});
    end
    n_checks++;
    if (instr_count !== 12'd1) begin n_fail++; $display("[TB] FAIL single_icount: got %0d want 1", instr_count); end
    n_checks++;
  endtask

  task automatic test_start();
    pulse_start();
    if ({done, cpu_hold, in_ready, err} !== 4'b0110) begin
      n_fail++; $display("[TB] FAIL start_flags: got done/hold/ready/err=%b want 0110", {done, cpu_hold, in_ready, err});
    end
    n_checks++;
    if (mem_addr !== 14'h2000 || instr_count !== 12'd0) begin
      n_fail++; $display("[TB] FAIL start_ptr: got addr=%h count=%0d want 2000/0", mem_addr, instr_count);
    end
    n_checks++;
    clear_log();
    send(pat(1), 1'b0);
    send(pat(2), 1'b1);
    in_valid = 1'b0;
    wait_write(14'h2001);
    pulse_start();
    wait_done(50);
    if (wr_addr.size() !== 6) begin
      n_fail++; $display("[TB] FAIL start_w1_count: got %0d writes want 6", wr_addr.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (wr_addr[k] !== addr_t'(14'h2000 + k) || wr_data[k] !== split(sent_q[k / 3], k % 3)) begin
          n_fail++; $display("[TB] FAIL start_w1_word%0d: got %h<=%h want %h<=%h", k, wr_addr[k], wr_data[k], 14'h2000 + k, split(sent_q[k / 3], k % 3));
        end
        n_checks++;
      end
    end
    n_checks++;
    if (instr_count !== 12'd2 || done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL start_w1_done: got count=%0d done=%b want 2/1", instr_count, done);
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    clear_log();
    saw_stall = 1'b0;
    for (int i = 0; i < 8; i++) send(pat(16 + i), (i == 7));
    in_valid = 1'b0;
    wait_done(200);
    if (wr_addr.size() !== 24) begin
      n_fail++; $display("[TB] FAIL b2b_count: got %0d writes want 24", wr_addr.size());
    end else begin
      for (int k = 0; k < 24; k++) begin
        if (wr_addr[k] !== addr_t'(14'h2000 + k) || wr_data[k] !== split(sent_q[k / 3], k % 3)
            || wr_cyc[k] !== wr_cyc[0] + k) begin
          n_fail++; $display("[TB] FAIL b2b_word%0d: got %h<=%h at cycle %0d want %h<=%h at %0d", k, wr_addr[k], wr_data[k], wr_cyc[k], 14'h2000 + k, split(sent_q[k / 3], k % 3), wr_cyc[0] + k);
        end
        n_checks++;
      end
    end
    n_checks++;
    if (saw_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_stall: in_ready never dropped, want a stall"); end
    n_checks++;
    if (instr_count !== 12'd8) begin n_fail++; $display("[TB] FAIL b2b_icount: got %0d want 8", instr_count); end
    n_checks++;
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    clear_log();
    send(pat(40), 1'b0);
    send(pat(41), 1'b0);
    send(pat(42), 1'b0);
    in_valid = 1'b0;
    wait_write(14'h2004);
    #1 rst = 1'b1;
    #1;
    if (mem_we !== 1'b0 || mem_addr !== 14'h2000 || mem_wdata !== 10'h000) begin
      n_fail++; $display("[TB] FAIL midrst_mem: got we=%b addr=%h data=%h want 0/2000/000", mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if ({cpu_hold, done, in_ready} !== 3'b101 || instr_count !== 12'd0) begin
      n_fail++; $display("[TB] FAIL midrst_flags: got hold/done/ready=%b count=%0d want 101/0", {cpu_hold, done, in_ready}, instr_count);
    end
    n_checks++;
    @(negedge clk);
    rst = 1'b0;
    tick(6);
    if (wr_addr.size() !== 5) begin
      n_fail++; $display("[TB] FAIL midrst_flushed: got %0d writes want 5", wr_addr.size());
    end
    n_checks++;
    clear_log();
    send(pat(43), 1'b1);
    in_valid = 1'b0;
    wait_done(50);
    if (wr_addr.size() !== 3) begin
      n_fail++; $display("[TB] FAIL midrst_reload_count: got %0d writes want 3", wr_addr.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr_addr[k] !== addr_t'(14'h2000 + k) || wr_data[k] !== split(sent_q[0], k)) begin
          n_fail++; $display("[TB] FAIL midrst_reload%0d: got %h<=%h want %h<=%h", k, wr_addr[k], wr_data[k], 14'h2000 + k, split(sent_q[0], k));
        end
        n_checks++;
      end
    end
    n_checks++;
  endtask

  task automatic test_host_stall();
    pulse_start();
    clear_log();
    send(pat(60), 1'b0);
    in_valid = 1'b0;
    tick(6);
    if (mem_we !== 1'b0 || instr_count !== 12'd1 || cpu_hold !== 1'b1 || wr_addr.size() !== 3) begin
      n_fail++; $display("[TB] FAIL stall_idle: got we=%b count=%0d hold=%b writes=%0d want 0/1/1/3", mem_we, instr_count, cpu_hold, wr_addr.size());
    end
    n_checks++;
    send(pat(61), 1'b0);
    in_valid = 1'b0;
    tick(7);
    send(pat(62), 1'b1);
    in_valid = 1'b0;
    wait_done(50);
    if (wr_addr.size() !== 9) begin
      n_fail++; $display("[TB] FAIL stall_count: got %0d writes want 9", wr_addr.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (wr_addr[k] !== addr_t'(14'h2000 + k) || wr_data[k] !== split(sent_q[k / 3], k % 3)) begin
          n_fail++; $display("[TB] FAIL stall_word%0d: got %h<=%h want %h<=%h", k, wr_addr[k], wr_data[k], 14'h2000 + k, split(sent_q[k / 3], k % 3));
        end
        n_checks++;
      end
    end
    n_checks++;
    if (instr_count !== 12'd3) begin n_fail++; $display("[TB] FAIL stall_icount: got %0d want 3", instr_count); end
    n_checks++;
  endtask

  task automatic test_overflow();
    int t;
    rst = 1'b1; tick(2); rst = 1'b0;
    clear_log();
    o_wr_addr.delete(); o_wr_data.delete();
    if (o_mem_addr !== 14'h3FFA) begin n_fail++; $display("[TB] FAIL ovf_base: got %h want 3FFA", o_mem_addr); end
    n_checks++;
    for (int i = 0; i < 3; i++) o_send(pat(80 + i));
    o_in_valid = 1'b0;
    for (t = 0; t < 100 && o_err !== 1'b1; t++) @(negedge clk);
    tick(5);
    if (o_wr_addr.size() !== 6) begin
      n_fail++; $display("[TB] FAIL ovf_count: got %0d writes want 6", o_wr_addr.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (o_wr_addr[k] !== addr_t'(14'h3FFA + k) || o_wr_data[k] !== split(sent_q[k / 3], k % 3)) begin
          n_fail++; $display("[TB] FAIL ovf_word%0d: got %h<=%h want %h<=%h", k, o_wr_addr[k], o_wr_data[k], 14'h3FFA + k, split(sent_q[k / 3], k % 3));
        end
        n_checks++;
      end
    end
    n_checks++;
    if ({o_err, o_cpu_hold, o_done, o_in_ready} !== 4'b1100 || o_instr_count !== 12'd2) begin
      n_fail++; $display("[TB] FAIL ovf_flags: got err/hold/done/ready=%b count=%0d want 1100/2", {o_err, o_cpu_hold, o_done, o_in_ready}, o_instr_count);
    end
    n_checks++;
    o_start = 1'b1; tick(1); o_start = 1'b0;
    if ({o_err, o_cpu_hold, o_in_ready} !== 3'b011 || o_mem_addr !== 14'h3FFA || o_instr_count !== 12'd0) begin
      n_fail++; $display("[TB] FAIL ovf_recover: got err/hold/ready=%b addr=%h count=%0d want 011/3FFA/0", {o_err, o_cpu_hold, o_in_ready}, o_mem_addr, o_instr_count);
    end
    n_checks++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_start();
    test_back_to_back();
    test_reset_mid_load();
    test_host_stall();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
